debounce_edge: RTL and testbench

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

---
 rtl/debounce_edge.sv | 120 ++++++++++++
 tb/tb_debounce_edge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_edge
//  Description : Two-flop synchronizer and debounce filter. Produces a clean
//                level with registered rise/fall pulses and a rise counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] event_count
);

    localparam int                c_SC_W       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [c_SC_W-1:0] c_STABLE_CNT = c_SC_W'(STABLE_CYCLES);
    localparam logic [c_SC_W-1:0] c_CNT_ONE    = c_SC_W'(1);

    localparam logic [0:0] c_ST_STABLE   = 1'b0;
    localparam logic [0:0] c_ST_SETTLING = 1'b1;

    logic              r_s1;
    logic              r_s2;
    logic [0:0]        r_state;
    logic [c_SC_W-1:0] r_cnt;
    logic              r_q;
    logic              r_rise;
    logic              r_fall;
    logic [CNT_W-1:0]  r_evt;

    logic [0:0]        w_state_nxt;
    logic [c_SC_W-1:0] w_cnt_nxt;
    logic [c_SC_W-1:0] w_cnt_inc;
    logic              w_toggle;
    logic              w_differs;

    assign w_cnt_inc = r_cnt + c_CNT_ONE;
    assign w_differs = (r_s2 != r_q);

    // State register; the synchronizer runs every cycle regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= c_ST_STABLE;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_evt   <= '0;
        end else begin
            r_s1    <= d;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= r_q ^ w_toggle;
            r_rise  <= w_toggle & ~r_q;
            r_fall  <= w_toggle & r_q;
            if (w_toggle && !r_q) begin
                r_evt <= r_evt + 1'b1;
            end
        end
    end

    // Next-state logic; with en low everything holds.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_toggle    = 1'b0;
        if (en) begin
            case (r_state)
                c_ST_STABLE: begin
                    if (w_differs) begin
                        if (STABLE_CYCLES == 1) begin
                            w_toggle = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_SETTLING;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                end
                c_ST_SETTLING: begin
                    if (!w_differs) begin
                        w_state_nxt = c_ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == c_STABLE_CNT) begin
                        w_toggle    = 1'b1;
                        w_state_nxt = c_ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        q           = r_q;
        rise        = r_rise;
        fall        = r_fall;
        busy        = (r_state == c_ST_SETTLING);
        event_count = r_evt;
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_edge
//  Description : Scenario bench for debounce_edge with an expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_edge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d   = 1'b0;
    logic       d2  = 1'b0;
    logic       en  = 1'b1;

    logic       q, rise, fall, busy;
    logic [7:0] event_count;
    logic       q2, rise2, fall2, busy2;
    logic [1:0] event_count2;

    logic [11:0] sb[$];
    logic [11:0] exp_v;
    logic [11:0] obs;
    logic [11:0] obs2;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .d(d), .en(en),
        .q(q), .rise(rise), .fall(fall), .busy(busy), .event_count(event_count)
    );

    debounce_edge #(.STABLE_CYCLES(4), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .d(d2), .en(en),
        .q(q2), .rise(rise2), .fall(fall2), .busy(busy2), .event_count(event_count2)
    );

    assign obs  = {q, rise, fall, busy, event_count};
    assign obs2 = {q2, rise2, fall2, busy2, 6'b0, event_count2};

    function automatic logic [11:0] mk(input logic eq, input logic er, input logic ef,
                                       input logic eb, input logic [7:0] ec);
        return {eq, er, ef, eb, ec};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; d = 1'b0; d2 = 1'b0; en = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; d = 1'b1; d2 = 1'b1; en = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset edge %0d: got %h expected %h", n, obs, exp_v);
            end
        end
        do_reset();
    endtask

    task automatic test_press(input logic [7:0] base);
        d = 1'b1; en = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            sb.push_back(mk(n >= 6, n == 6, 1'b0, n >= 3 && n <= 5, (n >= 6) ? base + 8'd1 : base));
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL press edge %0d: got %h expected %h", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_release(input logic [7:0] base);
        d = 1'b0; en = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            sb.push_back(mk(n < 6, 1'b0, n == 6, n >= 3 && n <= 5, base));
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL release edge %0d: got %h expected %h", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            d = (n <= 3);
            sb.push_back(mk(1'b0, 1'b0, 1'b0, n >= 3 && n <= 5, 8'd0));
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL glitch edge %0d: got %h expected %h", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        d = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            en = !(n == 4 || n == 5);
            sb.push_back(mk(n >= 8, n == 8, 1'b0, n >= 3 && n <= 7, (n >= 8) ? 8'd1 : 8'd0));
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL enable edge %0d: got %h expected %h", n, obs, exp_v);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid_settle();
        do_reset();
        d = 1'b1; en = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            rst = (n == 4);
            sb.push_back(mk(1'b0, 1'b0, 1'b0, n == 3, 8'd0));
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rst_mid edge %0d: got %h expected %h", n, obs, exp_v);
            end
        end
        rst = 1'b0;
        for (int m = 1; m <= 7; m++) begin
            sb.push_back(mk(m >= 6, m == 6, 1'b0, m >= 3 && m <= 5, (m >= 6) ? 8'd1 : 8'd0));
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rst_mid after-release edge %0d: got %h expected %h", m, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [1:0] cnt_before;
        logic [1:0] cnt_after;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cnt_before = 2'(k);
            cnt_after  = 2'(k + 1);
            d2 = 1'b1;
            for (int n = 1; n <= 8; n++) begin
                sb.push_back({n >= 6, n == 6, 1'b0, n >= 3 && n <= 5, 6'b0,
                              (n >= 6) ? cnt_after : cnt_before});
                tick();
                exp_v = sb.pop_front();
                n_checks++;
                if (obs2 !== exp_v) begin
                    n_fail++;
                    $display("FAIL wrap press %0d edge %0d: got %h expected %h", k, n, obs2, exp_v);
                end
            end
            d2 = 1'b0;
            for (int n = 1; n <= 8; n++) begin
                sb.push_back({n < 6, 1'b0, n == 6, n >= 3 && n <= 5, 6'b0, cnt_after});
                tick();
                exp_v = sb.pop_front();
                n_checks++;
                if (obs2 !== exp_v) begin
                    n_fail++;
                    $display("FAIL wrap release %0d edge %0d: got %h expected %h", k, n, obs2, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press(8'd0);
        test_release(8'd1);
        test_press(8'd1);
        test_release(8'd2);
        test_glitch();
        test_enable_gating();
        test_reset_mid_settle();
        test_back_to_back_wrap();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
